uart_bcd_collector: RTL and testbench

Parametrised collector that turns a stream of ASCII decimal digits from the UART byte receiver into a packed BCD word of `DIGITS` nibbles. Sits directly after the UART receiver and ahead of the BCD arithmetic blocks. Adds early termination, character validation, an inter-byte timeout and an optional sequential BCD-to-binary conversion.

---
 rtl/uart_bcd_pkg.sv | 22 ++
 rtl/bcd_to_bin_seq.sv | 53 +++++
 rtl/uart_bcd_collector.sv | 140 ++++++++++++++
 tb/tb_uart_bcd_collector.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bcd_pkg.sv
// Shared constants, FSM state type and width helper for the UART BCD collector.
// The optional binary conversion path is enabled by defining UART_BCD_BIN_EN.
package uart_bcd_pkg;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_CR = 8'h0D;

   typedef enum logic {IDLE, COLLECT} state_t;

   // Bits needed to hold any DIGITS-digit decimal value: ceil(log2(10^digits)).
   function automatic int bin_width(input int digits);
      longint pow10;
      int     w;
      pow10 = 1;
      for (int i = 0; i < digits; i++) pow10 = pow10 * 10;
      w = 0;
      while ((longint'(1) << w) < pow10) w++;
      return w;
   endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Only instantiated when UART_BCD_BIN_EN is defined.
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10,
   localparam int CNT_W = $clog2(DIGITS + 1)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic                busy,
   output logic                done,
   output logic [BIN_W-1:0]    bin_out
);

   logic [4*DIGITS-1:0] shreg;
   logic [BIN_W-1:0]    work;
   logic [BIN_W-1:0]    step;
   logic [CNT_W-1:0]    remaining;

   assign step = work * BIN_W'(10) + BIN_W'(shreg[4*DIGITS-1 -: 4]);

   // A start always wins, so a new snapshot silently replaces a running conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         work      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bin_out   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shreg     <= bcd_in;
            work      <= '0;
            remaining <= CNT_W'(DIGITS);
            busy      <= 1'b1;
         end else if (busy) begin
            work      <= step;
            shreg     <= shreg << 4;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
               busy    <= 1'b0;
               done    <= 1'b1;
               bin_out <= step;
            end
         end
      end
   end

endmodule

// File: rtl/uart_bcd_collector.sv
// Collects ASCII decimal digits from the UART receiver into a packed BCD word.
// Define UART_BCD_BIN_EN to add the sequential BCD-to-binary output (bin_data/bin_valid).
module uart_bcd_collector
   import uart_bcd_pkg::*;
#(
   parameter int          DIGITS      = 3,
   parameter logic [7:0]  TERM_CHAR   = ASCII_CR,
   parameter int          TIMEOUT_CYC = 0,
   localparam int         CNT_W       = $clog2(DIGITS + 1),
   localparam int         TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
`ifdef UART_BCD_BIN_EN
   , localparam int       BIN_W       = bin_width(DIGITS)
`endif
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                rx_valid,
   input  logic [7:0]          rx_byte,
   output logic [4*DIGITS-1:0] bcd_data,
   output logic                data_valid,
   output logic [CNT_W-1:0]    digit_count,
   output logic                busy,
   output logic                err
`ifdef UART_BCD_BIN_EN
   , output logic [BIN_W-1:0]  bin_data
   , output logic              bin_valid
`endif
);

   state_t              state, state_next;
   logic [4*DIGITS-1:0] acc, acc_next, bcd_next, nib_ext, shifted;
   logic [CNT_W-1:0]    cnt_next;
   logic [TO_W-1:0]     idle_cnt, idle_next;
   logic                dv_next, err_next, is_digit;

   assign busy = (state == COLLECT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         digit_count <= '0;
         bcd_data    <= '0;
         data_valid  <= 1'b0;
         err         <= 1'b0;
         idle_cnt    <= '0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         digit_count <= cnt_next;
         bcd_data    <= bcd_next;
         data_valid  <= dv_next;
         err         <= err_next;
         idle_cnt    <= idle_next;
      end
   end

   // Completing and aborting both drop straight back to IDLE, so the next byte can start a frame.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = digit_count;
      bcd_next   = bcd_data;
      dv_next    = 1'b0;
      err_next   = 1'b0;
      idle_next  = idle_cnt;
      is_digit   = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
      nib_ext    = '0;
      nib_ext[3:0] = rx_byte[3:0];
      shifted    = (acc << 4) | nib_ext;

      case (state)
         IDLE: begin
            if (rx_valid && is_digit) begin
               acc_next  = nib_ext;
               idle_next = '0;
               if (DIGITS == 1) begin
                  bcd_next = nib_ext;
                  dv_next  = 1'b1;
                  cnt_next = '0;
               end else begin
                  cnt_next   = CNT_W'(1);
                  state_next = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (rx_valid) begin
               idle_next = '0;
               if (is_digit) begin
                  acc_next = shifted;
                  if (digit_count == CNT_W'(DIGITS - 1)) begin
                     bcd_next   = shifted;
                     dv_next    = 1'b1;
                     cnt_next   = '0;
                     state_next = IDLE;
                  end else begin
                     cnt_next = digit_count + 1'b1;
                  end
               end else if (rx_byte == TERM_CHAR) begin
                  bcd_next   = acc;
                  dv_next    = 1'b1;
                  cnt_next   = '0;
                  state_next = IDLE;
               end else begin
                  err_next   = 1'b1;
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end else if (TIMEOUT_CYC > 0) begin
               if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  err_next   = 1'b1;
                  cnt_next   = '0;
                  idle_next  = '0;
                  state_next = IDLE;
               end else begin
                  idle_next = idle_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef UART_BCD_BIN_EN
   bcd_to_bin_seq #(
      .DIGITS (DIGITS),
      .BIN_W  (BIN_W)
   ) u_conv (
      .clk     (clk),
      .rst     (rst),
      .start   (data_valid),
      .bcd_in  (bcd_data),
      .busy    (),
      .done    (bin_valid),
      .bin_out (bin_data)
   );
`endif

endmodule

// File: tb/tb_uart_bcd_collector.sv
// Scoreboard bench for uart_bcd_collector: a 3-digit instance with a 16-cycle timeout
// and an 8-digit instance without timeout; binary outputs are checked when UART_BCD_BIN_EN is set.
module tb_uart_bcd_collector;
   import uart_bcd_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        v3, v8;
   logic [7:0]  b3, b8;
   logic [11:0] bcd3;
   logic [31:0] bcd8;
   logic        dv3, err3, busy3, dv8, err8, busy8;
   logic [1:0]  cnt3;
   logic [3:0]  cnt8;
`ifdef UART_BCD_BIN_EN
   localparam int BW3 = bin_width(3);
   localparam int BW8 = bin_width(8);
   logic [BW3-1:0] bin3;
   logic [BW8-1:0] bin8;
   logic           bv3, bv8;
   int             bq3[$];
   int             bq8[$];
   int             dv_cyc3 = 0, dv_cyc8 = 0;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      bit          is_err;
      logic [31:0] val;
   } exp_t;
   exp_t q3[$];
   exp_t q8[$];

   uart_bcd_collector #(.DIGITS(3), .TERM_CHAR(8'h0D), .TIMEOUT_CYC(16)) dut3 (
      .clk(clk), .rst(rst), .rx_valid(v3), .rx_byte(b3),
      .bcd_data(bcd3), .data_valid(dv3), .digit_count(cnt3), .busy(busy3), .err(err3)
`ifdef UART_BCD_BIN_EN
      , .bin_data(bin3), .bin_valid(bv3)
`endif
   );

   uart_bcd_collector #(.DIGITS(8), .TERM_CHAR(8'h0D), .TIMEOUT_CYC(0)) dut8 (
      .clk(clk), .rst(rst), .rx_valid(v8), .rx_byte(b8),
      .bcd_data(bcd8), .data_valid(dv8), .digit_count(cnt8), .busy(busy8), .err(err8)
`ifdef UART_BCD_BIN_EN
      , .bin_data(bin8), .bin_valid(bv8)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit to8, input logic [7:0] b);
      if (to8) begin
         b8 = b;
         v8 = 1'b1;
      end else begin
         b3 = b;
         v3 = 1'b1;
      end
      @(negedge clk);
      v3 = 1'b0;
      v8 = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushExp(input bit to8, input bit is_err, input logic [31:0] val,
                          input bit has_bin, input int bin_val);
      exp_t e;
      e.is_err = is_err;
      e.val    = val;
      if (to8) q8.push_back(e);
      else     q3.push_back(e);
`ifdef UART_BCD_BIN_EN
      if (has_bin) begin
         if (to8) bq8.push_back(bin_val);
         else     bq3.push_back(bin_val);
      end
`endif
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (dv3 || err3)) begin
         if (q3.size() == 0) begin
            checkOutput("dut3_unexpected_event", {30'b0, err3, dv3}, 32'h0);
         end else begin
            e = q3.pop_front();
            checkOutput("dut3_event_kind", {30'b0, err3, dv3}, e.is_err ? 32'h2 : 32'h1);
            checkOutput("dut3_bcd_data", {20'b0, bcd3}, e.val);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (dv8 || err8)) begin
         if (q8.size() == 0) begin
            checkOutput("dut8_unexpected_event", {30'b0, err8, dv8}, 32'h0);
         end else begin
            e = q8.pop_front();
            checkOutput("dut8_event_kind", {30'b0, err8, dv8}, e.is_err ? 32'h2 : 32'h1);
            checkOutput("dut8_bcd_data", bcd8, e.val);
         end
      end
   end

`ifdef UART_BCD_BIN_EN
   always @(negedge clk) begin
      if (!rst) begin
         if (dv3) dv_cyc3 = cyc;
         if (dv8) dv_cyc8 = cyc;
         if (bv3) begin
            if (bq3.size() == 0) checkOutput("dut3_bin_unexpected", 32'h1, 32'h0);
            else begin
               checkOutput("dut3_bin_data", 32'(bin3), bq3.pop_front());
               checkOutput("dut3_bin_latency", cyc - dv_cyc3, 4);
            end
         end
         if (bv8) begin
            if (bq8.size() == 0) checkOutput("dut8_bin_unexpected", 32'h1, 32'h0);
            else begin
               checkOutput("dut8_bin_data", 32'(bin8), bq8.pop_front());
               checkOutput("dut8_bin_latency", cyc - dv_cyc8, 9);
            end
         end
      end
   end
`endif

   initial begin
      rst = 1'b1;
      v3  = 1'b0;
      v8  = 1'b0;
      b3  = 8'h00;
      b8  = 8'h00;
      idleCycles(3);
      checkOutput("reset_bcd3", {20'b0, bcd3}, 32'h0);
      checkOutput("reset_flags3", {28'b0, dv3, err3, busy3, 1'b0}, 32'h0);
      checkOutput("reset_count3", {30'b0, cnt3}, 32'h0);
      checkOutput("reset_bcd8", bcd8, 32'h0);
      checkOutput("reset_flags8", {28'b0, dv8, err8, busy8, 1'b0}, 32'h0);
`ifdef UART_BCD_BIN_EN
      checkOutput("reset_bin3", 32'(bin3), 32'h0);
      checkOutput("reset_bin8", 32'(bin8), 32'h0);
`endif
      rst = 1'b0;
      idleCycles(1);

      // Full three-digit frame
      pushExp(0, 0, 32'h123, 1, 123);
      applyStimulus(0, "1");
      checkOutput("busy_after_first", {31'b0, busy3}, 32'h1);
      checkOutput("count_after_first", {30'b0, cnt3}, 32'h1);
      applyStimulus(0, "2");
      checkOutput("count_after_second", {30'b0, cnt3}, 32'h2);
      applyStimulus(0, "3");
      checkOutput("dv_after_third", {31'b0, dv3}, 32'h1);
      checkOutput("count_after_full", {30'b0, cnt3}, 32'h0);
      checkOutput("busy_after_full", {31'b0, busy3}, 32'h0);
      idleCycles(8);

      // Non-digits in IDLE are ignored
      applyStimulus(0, 8'h0D);
      applyStimulus(0, "X");
      checkOutput("idle_nondigit_err", {31'b0, err3}, 32'h0);
      checkOutput("idle_nondigit_busy", {31'b0, busy3}, 32'h0);
      idleCycles(2);

      // Short number terminated by CR
      pushExp(0, 0, 32'h042, 1, 42);
      applyStimulus(0, "4");
      applyStimulus(0, "2");
      applyStimulus(0, 8'h0D);
      checkOutput("dv_after_term", {31'b0, dv3}, 32'h1);
      checkOutput("count_after_term", {30'b0, cnt3}, 32'h0);
      idleCycles(8);

      // Abort keeps previous bcd_data, then a fresh frame
      pushExp(0, 1, 32'h042, 0, 0);
      applyStimulus(0, "7");
      applyStimulus(0, "A");
      checkOutput("err_after_bad", {31'b0, err3}, 32'h1);
      checkOutput("dv_after_bad", {31'b0, dv3}, 32'h0);
      checkOutput("busy_after_bad", {31'b0, busy3}, 32'h0);
      idleCycles(2);
      pushExp(0, 0, 32'h999, 1, 999);
      applyStimulus(0, "9");
      applyStimulus(0, "9");
      applyStimulus(0, "9");
      checkOutput("dv_after_999", {31'b0, dv3}, 32'h1);
      idleCycles(8);

      // Inter-byte timeout of 16 idle cycles
      pushExp(0, 1, 32'h999, 0, 0);
      applyStimulus(0, "5");
      idleCycles(15);
      checkOutput("timeout_busy_before", {31'b0, busy3}, 32'h1);
      checkOutput("timeout_err_before", {31'b0, err3}, 32'h0);
      idleCycles(1);
      checkOutput("timeout_err", {31'b0, err3}, 32'h1);
      checkOutput("timeout_busy_after", {31'b0, busy3}, 32'h0);
      idleCycles(4);

      // Reset mid-frame, with a digit strobed during reset
      applyStimulus(0, "8");
      applyStimulus(0, "8");
      rst = 1'b1;
      b3  = "3";
      v3  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      v3  = 1'b0;
      checkOutput("midreset_bcd3", {20'b0, bcd3}, 32'h0);
      checkOutput("midreset_count3", {30'b0, cnt3}, 32'h0);
      checkOutput("midreset_flags3", {29'b0, dv3, err3, busy3}, 32'h0);
`ifdef UART_BCD_BIN_EN
      checkOutput("midreset_bin3", 32'(bin3), 32'h0);
`endif
      pushExp(0, 0, 32'h001, 1, 1);
      applyStimulus(0, "1");
      applyStimulus(0, 8'h0D);
      checkOutput("dv_after_001", {31'b0, dv3}, 32'h1);
      idleCycles(8);

      // Eight nines back-to-back on the wide instance
      pushExp(1, 0, 32'h99999999, 1, 99999999);
      for (int i = 0; i < 8; i++) applyStimulus(1, "9");
      checkOutput("dv8_after_nines", {31'b0, dv8}, 32'h1);
      checkOutput("busy8_after_nines", {31'b0, busy8}, 32'h0);
      idleCycles(12);

      // Consecutive frames with no dead cycle; the second restarts the conversion
      pushExp(1, 0, 32'h12345678, 0, 0);
      for (int i = 1; i <= 8; i++) applyStimulus(1, 8'(8'h30 + i));
      checkOutput("dv8_after_seq", {31'b0, dv8}, 32'h1);
      pushExp(1, 0, 32'h00000001, 1, 1);
      applyStimulus(1, "1");
      checkOutput("busy8_no_dead_cycle", {31'b0, busy8}, 32'h1);
      checkOutput("count8_no_dead_cycle", {28'b0, cnt8}, 32'h1);
      applyStimulus(1, 8'h0D);
      checkOutput("dv8_after_short", {31'b0, dv8}, 32'h1);
      idleCycles(12);

      // No timeout when TIMEOUT_CYC is 0
      pushExp(1, 0, 32'h00000012, 1, 12);
      applyStimulus(1, "1");
      idleCycles(40);
      checkOutput("busy8_no_timeout", {31'b0, busy8}, 32'h1);
      checkOutput("err8_no_timeout", {31'b0, err8}, 32'h0);
      applyStimulus(1, "2");
      applyStimulus(1, 8'h0D);
      checkOutput("dv8_after_12", {31'b0, dv8}, 32'h1);
      idleCycles(20);

      checkOutput("q3_drained", q3.size(), 32'h0);
      checkOutput("q8_drained", q8.size(), 32'h0);
`ifdef UART_BCD_BIN_EN
      checkOutput("bq3_drained", bq3.size(), 32'h0);
      checkOutput("bq8_drained", bq8.size(), 32'h0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
